axi_to_mem_burst: RTL and testbench

AXI_TO_MEM_BURST -- requirements
Module: axi_to_mem_burst

---
 rtl/axi_to_mem_burst.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_to_mem_burst.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_to_mem_burst.sv
// AXI4 slave to single-port memory bridge, one burst in flight.
// Ports: clk_i/rst_i, busy_o, AXI AW/W/B/AR/R channels, mem_* req/gnt port.
module axi_to_mem_burst #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 4,
  parameter int MemBytes  = 65536
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   busy_o,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   r_last_o,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);
  localparam int StrbW = DataWidth / 8;
  localparam int OffW = $clog2(StrbW);
  localparam logic [2:0] MaxSize = 3'(OffW);
  localparam logic [AddrWidth:0] MemLim =
    (AddrWidth+1)'(MemBytes);
  localparam logic [AddrWidth-1:0] OffMask =
    AddrWidth'(StrbW - 1);

  typedef enum logic [2:0] {
    IDLE, WR, WRESP, RD_REQ, RD_WAIT, RD_RESP
  } state_e;

  state_e                 state_q;
  logic [IdWidth-1:0]     id_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             len_q;
  logic [7:0]             cnt_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic                   err_q;
  logic                   bad_q;
  logic                   prio_wr_q;
  logic [DataWidth-1:0]   rdata_q;
  logic [1:0]             rresp_q;
  logic                   rlast_q;

  logic                   idle, aw_fire, ar_fire;
  logic                   in_range, beat_ok, last_beat;
  logic                   w_fire, wrap_ok;
  logic [AddrWidth-1:0]   incr, wmask, sum;
  logic [AddrWidth-1:0]   addr_d;
  logic [IdWidth-1:0]     hd_id;
  logic [AddrWidth-1:0]   hd_addr;
  logic [7:0]             hd_len;
  logic [2:0]             hd_size;
  logic [1:0]             hd_burst;
  logic                   unused_wlast;

  assign unused_wlast = w_last_i;

  // Arbitration: ready only toward the valid channel that wins.
  assign idle = (state_q == IDLE) && !rst_i;
  assign aw_ready_o = idle && aw_valid_i &&
                      (!ar_valid_i || prio_wr_q);
  assign ar_ready_o = idle && ar_valid_i &&
                      (!aw_valid_i || !prio_wr_q);
  assign aw_fire = aw_valid_i && aw_ready_o;
  assign ar_fire = ar_valid_i && ar_ready_o;

  assign hd_id    = aw_fire ? aw_id_i    : ar_id_i;
  assign hd_addr  = aw_fire ? aw_addr_i  : ar_addr_i;
  assign hd_len   = aw_fire ? aw_len_i   : ar_len_i;
  assign hd_size  = aw_fire ? aw_size_i  : ar_size_i;
  assign hd_burst = aw_fire ? aw_burst_i : ar_burst_i;

  assign in_range  = {1'b0, addr_q} < MemLim;
  assign beat_ok   = !bad_q && in_range;
  assign last_beat = (cnt_q == len_q);

  assign wrap_ok = (len_q == 8'd1) || (len_q == 8'd3) ||
                   (len_q == 8'd7) || (len_q == 8'd15);

  always_comb begin
    incr  = AddrWidth'(1) << size_q;
    wmask = ((AddrWidth'(len_q) + AddrWidth'(1))
             << size_q) - AddrWidth'(1);
    sum   = addr_q + incr;
    addr_d = sum;
    if (burst_q == 2'b00) begin
      addr_d = addr_q;
    end else if (burst_q == 2'b10 && wrap_ok) begin
      addr_d = (addr_q & ~wmask) | (sum & wmask);
    end
  end

  // Out-of-range or illegal beats are swallowed without a memory access.
  assign w_ready_o = (state_q == WR) &&
                     (beat_ok ? mem_gnt_i : 1'b1);
  assign w_fire = w_valid_i && w_ready_o;

  assign mem_req_o = beat_ok &&
    (((state_q == WR) && w_valid_i) || (state_q == RD_REQ));
  assign mem_we_o    = (state_q == WR);
  assign mem_wdata_o = (state_q == WR) ? w_data_i : '0;
  assign mem_strb_o  = (state_q == WR) ? w_strb_i : '0;
  assign mem_addr_o  = addr_q & ~OffMask;

  assign busy_o    = (state_q != IDLE);
  assign b_valid_o = (state_q == WRESP);
  assign b_id_o    = id_q;
  assign b_resp_o  = err_q ? 2'b10 : 2'b00;
  assign r_valid_o = (state_q == RD_RESP);
  assign r_id_o    = id_q;
  assign r_data_o  = rdata_q;
  assign r_resp_o  = rresp_q;
  assign r_last_o  = (state_q == RD_RESP) && rlast_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
      prio_wr_q <= 1'b1;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_fire || ar_fire) begin
            id_q      <= hd_id;
            addr_q    <= hd_addr;
            len_q     <= hd_len;
            size_q    <= hd_size;
            burst_q   <= hd_burst;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            bad_q     <= (hd_burst == 2'b11) ||
                         (hd_size > MaxSize);
            prio_wr_q <= !aw_fire;
            state_q   <= aw_fire ? WR : RD_REQ;
          end
        end
        WR: begin
          if (w_fire) begin
            if (!beat_ok) err_q <= 1'b1;
            if (last_beat) begin
              state_q <= WRESP;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_d;
            end
          end
        end
        WRESP: begin
          if (b_ready_i) state_q <= IDLE;
        end
        RD_REQ: begin
          if (!beat_ok) begin
            rdata_q <= '0;
            rresp_q <= 2'b10;
            rlast_q <= last_beat;
            state_q <= RD_RESP;
          end else if (mem_gnt_i) begin
            rlast_q <= last_beat;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            rresp_q <= 2'b00;
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_ready_i) begin
            if (last_beat) begin
              rlast_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_d;
              state_q <= RD_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_to_mem_burst.sv
// Directed self-checking bench for axi_to_mem_burst.
// Memory model grants on gnt_en and returns {C0DE0000, addr} one cycle later.
module tb_axi_to_mem_burst;
  logic        clk = 0;
  logic        rst_i = 1;
  logic        busy_o;
  logic        aw_valid_i = 0, aw_ready_o;
  logic [3:0]  aw_id_i = 0;
  logic [31:0] aw_addr_i = 0;
  logic [7:0]  aw_len_i = 0;
  logic [2:0]  aw_size_i = 0;
  logic [1:0]  aw_burst_i = 0;
  logic        w_valid_i = 0, w_ready_o;
  logic [63:0] w_data_i = 0;
  logic [7:0]  w_strb_i = 0;
  logic        w_last_i = 0;
  logic        b_valid_o, b_ready_i = 0;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 0, ar_ready_o;
  logic [3:0]  ar_id_i = 0;
  logic [31:0] ar_addr_i = 0;
  logic [7:0]  ar_len_i = 0;
  logic [2:0]  ar_size_i = 0;
  logic [1:0]  ar_burst_i = 0;
  logic        r_valid_o, r_ready_i = 0;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_strb_o;
  logic        mem_rvalid_i = 0;
  logic [63:0] mem_rdata_i = 0;

  logic        gnt_en = 1;
  int          checks = 0;
  int          failures = 0;
  int          req_cnt = 0;
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [63:0] log_wd[$];

  assign mem_gnt_i = gnt_en;

  always #5 clk = ~clk;

  axi_to_mem_burst dut (
    .clk_i(clk), .rst_i(rst_i), .busy_o(busy_o),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always @(posedge clk) begin
    mem_rvalid_i <= mem_req_o && mem_gnt_i && !mem_we_o;
    mem_rdata_i  <= {32'hC0DE_0000, mem_addr_o};
    if (mem_req_o) req_cnt <= req_cnt + 1;
    if (mem_req_o && mem_gnt_i) begin
      log_addr.push_back(mem_addr_o);
      log_we.push_back(mem_we_o);
      log_wd.push_back(mem_wdata_o);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    log_addr.delete();
    log_we.delete();
    log_wd.delete();
  endtask

  task automatic aw_send(input logic [3:0] id,
                         input logic [31:0] a,
                         input logic [7:0] l,
                         input logic [2:0] s,
                         input logic [1:0] b);
    int n = 0;
    @(negedge clk);
    aw_id_i = id; aw_addr_i = a; aw_len_i = l;
    aw_size_i = s; aw_burst_i = b; aw_valid_i = 1;
    #1;
    while (!aw_ready_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!aw_ready_o) begin
      checks++; failures++;
      $display("FAIL aw_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    aw_valid_i = 0;
  endtask

  task automatic ar_send(input logic [3:0] id,
                         input logic [31:0] a,
                         input logic [7:0] l,
                         input logic [2:0] s,
                         input logic [1:0] b);
    int n = 0;
    @(negedge clk);
    ar_id_i = id; ar_addr_i = a; ar_len_i = l;
    ar_size_i = s; ar_burst_i = b; ar_valid_i = 1;
    #1;
    while (!ar_ready_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!ar_ready_o) begin
      checks++; failures++;
      $display("FAIL ar_timeout addr=%h", a);
    end
    @(posedge clk); #1;
    ar_valid_i = 0;
  endtask

  task automatic w_send(input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    w_data_i = d; w_strb_i = 8'hFF; w_valid_i = 1;
    #1;
    while (!w_ready_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!w_ready_o) begin
      checks++; failures++;
      $display("FAIL w_timeout data=%h", d);
    end
    @(posedge clk); #1;
    w_valid_i = 0;
  endtask

  task automatic b_take(output logic [3:0] id,
                        output logic [1:0] resp);
    int n = 0;
    @(negedge clk); #1;
    while (!b_valid_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!b_valid_o) begin
      checks++; failures++;
      $display("FAIL b_timeout");
    end
    id = b_id_o; resp = b_resp_o;
    b_ready_i = 1;
    @(posedge clk); #1;
    b_ready_i = 0;
  endtask

  task automatic r_take(output logic [63:0] d,
                        output logic [1:0] resp,
                        output logic last);
    int n = 0;
    @(negedge clk); #1;
    while (!r_valid_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!r_valid_o) begin
      checks++; failures++;
      $display("FAIL r_timeout");
    end
    d = r_data_o; resp = r_resp_o; last = r_last_o;
    r_ready_i = 1;
    @(posedge clk); #1;
    r_ready_i = 0;
  endtask

  task automatic test_reset();
    aw_valid_i = 1; ar_valid_i = 1; w_valid_i = 1;
    @(negedge clk); #1;
    checks++;
    if ({aw_ready_o, ar_ready_o, w_ready_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ready got=%b want=000",
               {aw_ready_o, ar_ready_o, w_ready_o});
    end
    checks++;
    if ({busy_o, b_valid_o, r_valid_o, r_last_o, mem_req_o}
        !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=00000",
        {busy_o, b_valid_o, r_valid_o, r_last_o, mem_req_o});
    end
    checks++;
    if ({r_data_o, r_resp_o, r_id_o, b_resp_o, b_id_o}
        !== '0) begin
      failures++;
      $display("FAIL reset_regs rdata=%h rresp=%b",
               r_data_o, r_resp_o);
    end
    aw_valid_i = 0; ar_valid_i = 0; w_valid_i = 0;
    @(negedge clk);
    rst_i = 0;
  endtask

  task automatic test_tie();
    logic [3:0] id; logic [1:0] rs;
    logic [63:0] d; logic lst;
    do_reset();
    @(negedge clk);
    aw_id_i = 1; aw_addr_i = 32'h100; aw_len_i = 0;
    aw_size_i = 3; aw_burst_i = 1; aw_valid_i = 1;
    ar_id_i = 2; ar_addr_i = 32'h200; ar_len_i = 0;
    ar_size_i = 3; ar_burst_i = 1; ar_valid_i = 1;
    #1;
    checks++;
    if ({aw_ready_o, ar_ready_o} !== 2'b10) begin
      failures++;
      $display("FAIL tie1 aw/ar_ready got=%b want=10",
               {aw_ready_o, ar_ready_o});
    end
    @(posedge clk); #1;
    aw_valid_i = 0;
    w_send(64'h55);
    b_take(id, rs);
    @(negedge clk);
    aw_valid_i = 1;
    #1;
    checks++;
    if ({aw_ready_o, ar_ready_o} !== 2'b01) begin
      failures++;
      $display("FAIL tie2 aw/ar_ready got=%b want=01",
               {aw_ready_o, ar_ready_o});
    end
    @(posedge clk); #1;
    aw_valid_i = 0; ar_valid_i = 0;
    r_take(d, rs, lst);
    checks++;
    if (d !== 64'hC0DE_0000_0000_0200 || rs !== 2'b00 ||
        r_id_o !== 4'd2) begin
      failures++;
      $display("FAIL tie2_read data=%h resp=%b want=%h/00",
               d, rs, 64'hC0DE_0000_0000_0200);
    end
  endtask

  task automatic test_write_incr();
    logic [3:0] id; logic [1:0] rs;
    logic [31:0] ea[4];
    ea = '{32'h10, 32'h18, 32'h20, 32'h28};
    do_reset();
    gnt_en = 1;
    aw_send(3, 32'h10, 3, 3, 1);
    for (int i = 0; i < 4; i++)
      w_send(64'h0123_4567_0000_0000 + 64'(i));
    b_take(id, rs);
    checks++;
    if (id !== 4'd3 || rs !== 2'b00) begin
      failures++;
      $display("FAIL wr_b id=%0d resp=%b want=3/00", id, rs);
    end
    checks++;
    if (log_addr.size() != 4) begin
      failures++;
      $display("FAIL wr_beats got=%0d want=4", log_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_we[i] !== 1'b1 ||
            log_wd[i] !== 64'h0123_4567_0000_0000 + 64'(i)) begin
          failures++;
          $display("FAIL wr_beat%0d addr=%h we=%b want=%h/1",
                   i, log_addr[i], log_we[i], ea[i]);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL wr_idle busy=%b want=0", busy_o);
    end
  endtask

  task automatic test_read_wrap();
    logic [63:0] d; logic [1:0] rs; logic lst;
    logic [31:0] ea[4];
    ea = '{32'h38, 32'h20, 32'h28, 32'h30};
    log_addr.delete(); log_we.delete(); log_wd.delete();
    ar_send(5, 32'h38, 3, 3, 2);
    for (int i = 0; i < 4; i++) begin
      r_take(d, rs, lst);
      checks++;
      if (d !== {32'hC0DE_0000, ea[i]} || rs !== 2'b00 ||
          lst !== (i == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d data=%h resp=%b last=%b",
                 i, d, rs, lst);
      end
    end
    checks++;
    if (log_addr.size() != 4 || log_addr[0] !== ea[0] ||
        log_addr[1] !== ea[1] || log_addr[2] !== ea[2] ||
        log_addr[3] !== ea[3] || log_we[0] !== 1'b0) begin
      failures++;
      $display("FAIL wrap_addrs n=%0d a1=%h want=%h",
               log_addr.size(), log_addr[1], ea[1]);
    end
  endtask

  task automatic test_read_oor();
    logic [63:0] d; logic [1:0] rs; logic lst;
    log_addr.delete(); log_we.delete(); log_wd.delete();
    ar_send(6, 32'hFFF8, 1, 3, 1);
    r_take(d, rs, lst);
    checks++;
    if (d !== 64'hC0DE_0000_0000_FFF8 || rs !== 2'b00 ||
        lst !== 1'b0) begin
      failures++;
      $display("FAIL oor_beat0 data=%h resp=%b last=%b",
               d, rs, lst);
    end
    r_take(d, rs, lst);
    checks++;
    if (d !== 64'h0 || rs !== 2'b10 || lst !== 1'b1) begin
      failures++;
      $display("FAIL oor_beat1 data=%h resp=%b want=0/10",
               d, rs);
    end
    checks++;
    if (log_addr.size() != 1) begin
      failures++;
      $display("FAIL oor_memcnt got=%0d want=1",
               log_addr.size());
    end
  endtask

  task automatic test_bad_burst();
    logic [3:0] id; logic [1:0] rs;
    logic [63:0] d; logic lst;
    int rc0;
    gnt_en = 0;
    rc0 = req_cnt;
    aw_send(7, 32'h0, 1, 3, 2'b11);
    w_send(64'h1);
    w_send(64'h2);
    b_take(id, rs);
    checks++;
    if (id !== 4'd7 || rs !== 2'b10) begin
      failures++;
      $display("FAIL bad_burst_b id=%0d resp=%b want=7/10",
               id, rs);
    end
    ar_send(8, 32'h0, 0, 4, 1);
    r_take(d, rs, lst);
    checks++;
    if (d !== 64'h0 || rs !== 2'b10 || lst !== 1'b1) begin
      failures++;
      $display("FAIL bad_size_r data=%h resp=%b want=0/10",
               d, rs);
    end
    checks++;
    if (req_cnt != rc0) begin
      failures++;
      $display("FAIL bad_noreq got=%0d want=%0d", req_cnt, rc0);
    end
    gnt_en = 1;
  endtask

  task automatic test_stall();
    logic [63:0] d; logic [1:0] rs; logic lst;
    int n = 0;
    gnt_en = 0;
    ar_send(9, 32'h44, 0, 2, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
        failures++;
        $display("FAIL gnt_stall%0d req=%b addr=%h want=1/40",
                 k, mem_req_o, mem_addr_o);
      end
    end
    gnt_en = 1;
    @(negedge clk); #1;
    while (!r_valid_o && n < 20) begin
      @(negedge clk); #1; n++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (r_valid_o !== 1'b1 ||
          r_data_o !== 64'hC0DE_0000_0000_0040) begin
        failures++;
        $display("FAIL r_stall%0d valid=%b data=%h",
                 k, r_valid_o, r_data_o);
      end
      @(negedge clk); #1;
    end
    r_take(d, rs, lst);
    checks++;
    if (d !== 64'hC0DE_0000_0000_0040 || lst !== 1'b1) begin
      failures++;
      $display("FAIL stall_take data=%h last=%b", d, lst);
    end
  endtask

  task automatic test_abort();
    int bseen = 0;
    do_reset();
    gnt_en = 1;
    aw_send(2, 32'h80, 3, 3, 1);
    w_send(64'hA0);
    w_send(64'hA1);
    @(negedge clk);
    w_data_i = 64'hA2; w_valid_i = 1;
    #1;
    rst_i = 1;
    #1;
    checks++;
    if ({busy_o, b_valid_o, w_ready_o, mem_req_o,
         aw_ready_o, r_valid_o} !== 6'b0) begin
      failures++;
      $display("FAIL abort_outs got=%b want=000000",
        {busy_o, b_valid_o, w_ready_o, mem_req_o,
         aw_ready_o, r_valid_o});
    end
    w_valid_i = 0;
    @(negedge clk);
    rst_i = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (b_valid_o || busy_o) bseen++;
    end
    checks++;
    if (bseen != 0) begin
      failures++;
      $display("FAIL abort_noresp cycles=%0d want=0", bseen);
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_write_incr();
    test_read_wrap();
    test_read_oor();
    test_bad_burst();
    test_stall();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
